// File: rtl/sha1_pkg.sv
// Shared SHA-1 constants, state type and helpers for the schedule and round stages.
package sha1_pkg;

  localparam int unsigned SHA1_ROUNDS = 80;
  localparam int unsigned SHA1_WIN    = 16;

  localparam logic [31:0] SHA1_K0 = 32'h5A82_7999;
  localparam logic [31:0] SHA1_K1 = 32'h6ED9_EBA1;
  localparam logic [31:0] SHA1_K2 = 32'h8F1B_BCDC;
  localparam logic [31:0] SHA1_K3 = 32'hCA62_C1D6;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun
  } sha1_state_e;

  function automatic logic [31:0] rotl1(input logic [31:0] x);
    return {x[30:0], x[31]};
  endfunction

  // Round constant for round index t (0..79).
  function automatic logic [31:0] sha1_k(input logic [6:0] t);
    if (t < 7'd20) begin
      return SHA1_K0;
    end else if (t < 7'd40) begin
      return SHA1_K1;
    end else if (t < 7'd60) begin
      return SHA1_K2;
    end
    return SHA1_K3;
  endfunction

endpackage

// File: rtl/sha1_w_expand.sv
// One SHA-1 schedule expansion step: rotl1(W[t-3] ^ W[t-8] ^ W[t-14] ^ W[t-16]).
module sha1_w_expand
  import sha1_pkg::*;
(
  input  logic [31:0] i_w3,
  input  logic [31:0] i_w8,
  input  logic [31:0] i_w14,
  input  logic [31:0] i_w16,
  output logic [31:0] o_w
);

  assign o_w = rotl1(i_w3 ^ i_w8 ^ i_w14 ^ i_w16);

endmodule

// File: rtl/sha1_w_sched.sv
// SHA-1 message schedule: loads 16 block words, then streams W[0..79] on consumer advance.
module sha1_w_sched
  import sha1_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_abort,
  input  logic        i_load_valid,
  input  logic [31:0] i_load_word,
  output logic        o_load_ready,
  output logic [31:0] o_w,
  output logic        o_w_valid,
  input  logic        i_w_next,
  output logic [6:0]  o_t,
  output logic        o_last,
  output logic        o_done
);

  localparam logic [6:0] LastT = 7'(SHA1_ROUNDS - 1);
  localparam int         Win   = int'(SHA1_WIN);

  sha1_state_e r_state, w_state_d;
  logic [3:0]  r_cnt, w_cnt_d;
  logic [6:0]  r_t, w_t_d;
  logic        r_done, w_done_d;
  logic [31:0] r_win [Win];

  logic        w_in_run;
  logic        w_accept;
  logic        w_shift;
  logic [31:0] w_expand;
  logic [31:0] w_shift_in;

  assign w_in_run   = (r_state == StRun);
  assign w_accept   = i_load_valid && !w_in_run;
  assign w_shift    = w_accept || (w_in_run && i_w_next);
  assign w_shift_in = w_in_run ? w_expand : i_load_word;

  // Window invariant r_win[k] = W[t+k]; taps give the word that lands at W[t+16].
  sha1_w_expand u_expand (
    .i_w3  (r_win[13]),
    .i_w8  (r_win[8]),
    .i_w14 (r_win[2]),
    .i_w16 (r_win[0]),
    .o_w   (w_expand)
  );

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_t_d     = r_t;
    w_done_d  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_d = StLoad;
          w_cnt_d   = 4'd1;
        end
      end
      StLoad: begin
        if (w_accept) begin
          if (r_cnt == 4'd15) begin
            w_state_d = StRun;
            w_cnt_d   = 4'd0;
            w_t_d     = 7'd0;
          end else begin
            w_cnt_d = r_cnt + 4'd1;
          end
        end
      end
      StRun: begin
        if (i_w_next) begin
          if (r_t == LastT) begin
            w_state_d = StIdle;
            w_t_d     = 7'd0;
            w_done_d  = 1'b1;
          end else begin
            w_t_d = r_t + 7'd1;
          end
        end
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = 4'd0;
        w_t_d     = 7'd0;
      end
    endcase
  end

  // Abort has priority over a simultaneous load word.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_abort) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
      r_t     <= 7'd0;
      r_done  <= 1'b0;
      for (int k = 0; k < Win; k++) begin
        r_win[k] <= 32'd0;
      end
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_t     <= w_t_d;
      r_done  <= w_done_d;
      if (w_shift) begin
        for (int k = 0; k < Win - 1; k++) begin
          r_win[k] <= r_win[k+1];
        end
        r_win[Win-1] <= w_shift_in;
      end
    end
  end

  assign o_w          = r_win[0];
  assign o_w_valid    = w_in_run;
  assign o_load_ready = !w_in_run;
  assign o_t          = r_t;
  assign o_last       = w_in_run && (r_t == LastT);
  assign o_done       = r_done;

endmodule

// File: tb/tb_sha1_w_sched.sv
// Self-checking bench for sha1_w_sched against an array-based FIPS 180 schedule model.
module tb_sha1_w_sched;

  logic        clk;
  logic        i_reset, i_abort, i_load_valid, i_w_next;
  logic [31:0] i_load_word;
  logic        o_load_ready, o_w_valid, o_last, o_done;
  logic [31:0] o_w;
  logic [6:0]  o_t;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] blk   [16];
  logic [31:0] m_w   [80];
  logic [31:0] got_w [80];

  typedef struct {
    int          idx;
    logic [31:0] exp;
  } vec_t;

  vec_t abc_vec [6];

  sha1_w_sched dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_abort      (i_abort),
    .i_load_valid (i_load_valid),
    .i_load_word  (i_load_word),
    .o_load_ready (o_load_ready),
    .o_w          (o_w),
    .o_w_valid    (o_w_valid),
    .i_w_next     (i_w_next),
    .o_t          (o_t),
    .o_last       (o_last),
    .o_done       (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, {31'd0, act}, {31'd0, exp});
  endtask

  // Schedule straight from the recurrence, indexed by absolute round.
  task automatic model_compute();
    logic [31:0] x;
    for (int t = 0; t < 80; t++) begin
      if (t < 16) begin
        m_w[t] = blk[t];
      end else begin
        x      = m_w[t-3] ^ m_w[t-8] ^ m_w[t-14] ^ m_w[t-16];
        m_w[t] = {x[30:0], x[31]};
      end
    end
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    blk[0]  = 32'h6162_6380;
    blk[15] = 32'h0000_0018;
    model_compute();
  endtask

  task automatic set_random();
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    model_compute();
  endtask

  // Drive blk[] in; optional idle cycle before each word; start_now drives in current cycle.
  task automatic load_block(input bit gaps, input bit start_now);
    for (int i = 0; i < 16; i++) begin
      if (gaps) begin
        @(negedge clk);
        check1("gap_w_valid", o_w_valid, 1'b0);
        i_load_valid = 1'b0;
        i_load_word  = $urandom;
      end
      if (!(start_now && i == 0 && !gaps)) @(negedge clk);
      check1("load_w_valid", o_w_valid, 1'b0);
      check1("load_ready", o_load_ready, 1'b1);
      i_load_valid = 1'b1;
      i_load_word  = blk[i];
    end
    @(negedge clk);
    i_load_valid = 1'b0;
    check1("w0_valid", o_w_valid, 1'b1);
    check("w0", o_w, m_w[0]);
    check("t0", {25'd0, o_t}, 32'd0);
  endtask

  // Consume all 80 words, advancing every `period` cycles; checks hold between advances.
  task automatic run_block(input int period);
    int t_exp = 0;
    int cyc   = 0;
    i_w_next = 1'b0;
    while (t_exp < 80 && cyc < 1000) begin
      @(negedge clk);
      check1("run_w_valid", o_w_valid, 1'b1);
      check("run_w", o_w, m_w[t_exp]);
      check("run_t", {25'd0, o_t}, 32'(t_exp));
      check1("run_last", o_last, t_exp == 79);
      check1("run_done", o_done, 1'b0);
      if (cyc % period == 0) begin
        got_w[t_exp] = o_w;
        i_w_next     = 1'b1;
        t_exp++;
      end else begin
        i_w_next = 1'b0;
      end
      cyc++;
    end
    if (cyc >= 1000) begin
      n_cmp++;
      n_fail++;
      $display("FAIL run_timeout: got t=%0d, expected 80", t_exp);
    end
    @(negedge clk);
    i_w_next = 1'b0;
    check1("done_pulse", o_done, 1'b1);
    check1("done_w_valid", o_w_valid, 1'b0);
    check1("done_load_ready", o_load_ready, 1'b1);
  endtask

  initial begin
    abc_vec[0] = '{0,  32'h6162_6380};
    abc_vec[1] = '{15, 32'h0000_0018};
    abc_vec[2] = '{16, 32'hC2C4_C700};
    abc_vec[3] = '{17, 32'h0000_0000};
    abc_vec[4] = '{18, 32'h0000_0030};
    abc_vec[5] = '{19, 32'h8589_8E01};

    i_reset      = 1'b1;
    i_abort      = 1'b0;
    i_load_valid = 1'b0;
    i_load_word  = 32'd0;
    i_w_next     = 1'b0;
    repeat (3) @(negedge clk);
    i_reset = 1'b0;
    check("rst_w", o_w, 32'd0);
    check1("rst_w_valid", o_w_valid, 1'b0);
    check1("rst_last", o_last, 1'b0);
    check1("rst_done", o_done, 1'b0);
    check1("rst_load_ready", o_load_ready, 1'b1);
    check("rst_t", {25'd0, o_t}, 32'd0);

    // "abc" block, continuous advance, checked against the fixed table.
    set_abc();
    load_block(1'b0, 1'b0);
    run_block(1);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("abc_W%0d", abc_vec[i].idx), got_w[abc_vec[i].idx], abc_vec[i].exp);
    end
    @(negedge clk);
    check1("done_one_cycle", o_done, 1'b0);

    // Load with alternating gaps, then stalled consumer.
    load_block(1'b1, 1'b0);
    run_block(3);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("stall_W%0d", abc_vec[i].idx), got_w[abc_vec[i].idx], abc_vec[i].exp);
    end

    // Abort mid-RUN at t=40.
    load_block(1'b0, 1'b0);
    i_w_next = 1'b1;
    repeat (40) @(negedge clk);
    i_w_next = 1'b0;
    check("pre_abort_t", {25'd0, o_t}, 32'd40);
    check("pre_abort_w", o_w, m_w[40]);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    check1("abort_w_valid", o_w_valid, 1'b0);
    check("abort_t", {25'd0, o_t}, 32'd0);
    check("abort_w", o_w, 32'd0);
    check1("abort_done", o_done, 1'b0);
    check1("abort_load_ready", o_load_ready, 1'b1);
    @(negedge clk);
    check1("abort_done_late", o_done, 1'b0);
    load_block(1'b0, 1'b0);
    run_block(1);
    check("reload_W16", got_w[16], 32'hC2C4_C700);

    // Reset after 7 load words, then abort colliding with a load word.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      i_load_valid = 1'b1;
      i_load_word  = $urandom;
    end
    @(negedge clk);
    i_load_valid = 1'b0;
    i_reset      = 1'b1;
    @(negedge clk);
    i_reset      = 1'b0;
    check("midload_rst_w", o_w, 32'd0);
    i_abort      = 1'b1;
    i_load_valid = 1'b1;
    i_load_word  = 32'hDEAD_BEEF;
    @(negedge clk);
    i_abort      = 1'b0;
    i_load_valid = 1'b0;
    load_block(1'b0, 1'b0);
    run_block(1);
    check("midload_W0", got_w[0], 32'h6162_6380);

    // Back-to-back: block 2 starts in the done cycle.
    set_random();
    load_block(1'b0, 1'b1);
    run_block(1);

    // Randomised blocks, gap patterns and stall rates.
    for (int r = 0; r < 4; r++) begin
      set_random();
      load_block(1'($urandom_range(0, 1)), 1'b0);
      run_block(int'($urandom_range(1, 4)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sha1_w_sched.md
# sha1_w_sched

SHA-1 message-schedule generator that sits directly upstream of the SHA-1 round stages and drives their `w` input. It accepts one 512-bit message block as 16 consecutive 32-bit words, then produces W[0]..W[79] one word per advance, in step with the round stages' `next` strobe. Expansion uses a 16-deep shift window with W[t] = rotl1(W[t-3] ^ W[t-8] ^ W[t-14] ^ W[t-16]).

## Interface
- No parameters. Round count and window depth are fixed constants; see Structure.
- `clk` in 1: single clock, all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `abort` in 1: synchronous clear to IDLE. Same effect as `reset`.
- `load_valid` in 1: `load_word` is valid this cycle.
- `load_word` in 32: message word. Big-endian order, word 0 first.
- `load_ready` out 1: block accepts a load word this cycle.
- `w` out 32: current schedule word W[t]. Driven straight from a register, no combinational path from the inputs.
- `w_valid` out 1: `w` and `t` are valid.
- `w_next` in 1: consumer advance. Asserted together with the round stages' `next`.
- `t` out 7: current round index, 0..79.
- `last` out 1: `w_valid && t==79`.
- `done` out 1: one-cycle pulse after W[79] is consumed.

## Operation
- Window registers s[0..15], with invariant s[k] = W[t+k]. Output `w` = s[0].
- FSM states:
  - IDLE
    - `load_ready`=1.
    - An accepted word (`load_valid && load_ready`) moves to LOAD with cnt=1.
  - LOAD
    - `load_ready`=1.
    - Each accepted word shifts in: s[i]<=s[i+1], s[15]<=`load_word`, cnt++.
    - The 16th accepted word moves to RUN with t=0.
    - Load gaps (`load_valid`=0) are allowed and hold state.
  - RUN
    - `load_ready`=0, `w_valid`=1.
    - On `w_next`: s[i]<=s[i+1], s[15]<=rotl1(s[13]^s[8]^s[2]^s[0]), t++.
    - On `w_next` with t==79: go to IDLE and pulse `done`.
- The IDLE shift also applies to the first accepted word. After 16 accepts, s[0]=word0.
- `w_next` is ignored outside RUN. `load_valid` is ignored in RUN.
- Expansion continues for t≥64 even though those words are never consumed. This is harmless and keeps the logic uniform.
- Arithmetic is XOR/rotate only, 32-bit, with no carries.

## Timing
- Reset or abort values:
  - state=IDLE, cnt=0, t=0
  - s[*]=0, so `w`=0
  - `w_valid`=0, `last`=0, `done`=0, `load_ready`=1
- Load-to-output latency: W[0] appears on `w` with `w_valid`=1 in the cycle after the 16th load word is accepted.
- Advance latency: after a `w_next` edge, `w` shows W[t+1] the next cycle. Throughput is one word per cycle with `w_next` held high.
- `done` is high in the first IDLE cycle only. `load_ready` is already 1 in that cycle, so the next block can start loading immediately (back-to-back blocks).
- `abort` or `reset` mid-LOAD discards partial words. Mid-RUN it drops `w_valid` on the next cycle with no `done` pulse.
- If `abort` and `load_valid` are asserted together, `abort` wins and the word is not accepted.
- Consumer contract: the round controller asserts `feed` to the round stages before the first `w_next`, and `w_next` only while `w_valid`=1.

## Structure
- Shared package `sha1_pkg`:
  - `SHA1_ROUNDS`=80, `SHA1_WIN`=16.
  - state enum {IDLE, LOAD, RUN}.
  - function `rotl1`.
  - Round K constants, also used by the round stages.
- One sub-module: `sha1_w_expand`. Purely combinational: four 32-bit inputs in, rotl1 of their XOR out. It is reusable by an unrolled schedule later.
- Top level holds the FSM, cnt, t, and the window.

## Test plan
- "abc" block: load 0x61626380, then 14×0x00000000, then 0x00000018, then hold `w_next`=1. Required:
  - W0=0x61626380, W15=0x00000018.
  - W16=0xC2C4C700, W17=0x00000000, W18=0x00000030, W19=0x85898E01.
  - `last` at t=79, `done` one cycle later.
- Load with gaps: toggle `load_valid` 1/0 over 32 cycles. Required: identical W sequence to the "abc" case; `w_valid` rises only after the 16th accepted word.
- Stalled consumer: in RUN, pulse `w_next` every 3rd cycle. Required: `w` and `t` hold between pulses; sequence identical to the "abc" case.
- Abort mid-RUN at t=40. Required: next cycle state=IDLE, `w_valid`=0, `t`=0, `w`=0, no `done`. Reloading "abc" then gives W16=0xC2C4C700.
- Reset mid-LOAD after 7 words, then load the full "abc" block. Required: W0=0x61626380, i.e. no stale words.
- Back-to-back blocks: present block 2 words starting in the `done` cycle. Required: accepted immediately; block 2 W0 appears 16 accepts later.
